// File: rtl/useq_pkg.sv
// Shared types and width helpers for the microcode sequencer.
package useq_pkg;

    typedef enum logic [2:0] {
        NEXT     = 3'd0,
        JUMP     = 3'd1,
        BR_Z     = 3'd2,
        DISPATCH = 3'd3,
        WAIT     = 3'd4,
        CALL     = 3'd5,
        RET      = 3'd6,
        FETCH    = 3'd7
    } next_e;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/useq_if.sv
// Microword sequencing fields, dispatch-RAM write port and sequencer status.
interface useq_if
    import useq_pkg::*;
#(
    parameter int UPC_W       = 8,
    parameter int OPC_W       = 7,
    parameter int NUM_TBL     = 2,
    parameter int STACK_DEPTH = 4
);
    localparam int TBL_W   = clog2_min1(NUM_TBL);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    next_e              next_sel;
    logic [UPC_W-1:0]   target;
    logic [TBL_W-1:0]   tbl_sel;
    logic [OPC_W-1:0]   opcode;
    logic               alu_zero;
    logic               mem_busy;
    logic               disp_we;
    logic [TBL_W-1:0]   disp_tbl;
    logic [OPC_W-1:0]   disp_opc;
    logic [UPC_W-1:0]   disp_data;
    logic [UPC_W-1:0]   upc;
    logic               stall;
    logic [DEPTH_W-1:0] depth;
    logic               err_ovf;
    logic               err_unf;

    modport master (
        output next_sel, target, tbl_sel, opcode, alu_zero, mem_busy,
               disp_we, disp_tbl, disp_opc, disp_data,
        input  upc, stall, depth, err_ovf, err_unf
    );

    modport slave (
        input  next_sel, target, tbl_sel, opcode, alu_zero, mem_busy,
               disp_we, disp_tbl, disp_opc, disp_data,
        output upc, stall, depth, err_ovf, err_unf
    );

endinterface

// File: rtl/useq_stack.sv
// Return-address LIFO for micro-subroutines; flush has priority over push/pop.
// Latency: push/pop/flush take effect on the next rising edge; dout is combinational top-of-stack.
// Backpressure: none; push when full and pop when empty are ignored, caller checks full/empty.
module useq_stack
    import useq_pkg::*;
#(
    parameter int UPC_W       = 8,
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [UPC_W-1:0]   din,
    output logic [UPC_W-1:0]   dout,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);
    localparam int PTR_W = clog2_min1(STACK_DEPTH);

    logic [UPC_W-1:0] mem [STACK_DEPTH];

    assign full  = (depth == DEPTH_W'(STACK_DEPTH));
    assign empty = (depth == '0);
    assign dout  = mem[PTR_W'(depth - DEPTH_W'(1))];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth <= '0;
        end else if (flush) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + DEPTH_W'(1);
        end else if (pop && !empty) begin
            depth <= depth - DEPTH_W'(1);
        end
    end

    // Entry storage needs no reset: depth alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full && !flush) begin
            mem[PTR_W'(depth)] <= din;
        end
    end

endmodule

// File: rtl/useq.sv
// Microcode sequencer: registers the next microcode address from the microword sequencing op.
// Latency: one cycle from microword decision to new upc; one microword per cycle.
// Backpressure: WAIT holds upc and raises stall while mem_busy is high.
module useq
    import useq_pkg::*;
#(
    parameter int               UPC_W       = 8,
    parameter int               OPC_W       = 7,
    parameter int               NUM_TBL     = 2,
    parameter int               STACK_DEPTH = 4,
    parameter logic [UPC_W-1:0] RESET_UPC   = '0,
    parameter logic [UPC_W-1:0] TRAP_UPC    = {UPC_W{1'b1}}
) (
    input  logic  clk,
    input  logic  reset,
    useq_if.slave bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [UPC_W-1:0]   disp_ram [NUM_TBL][2**OPC_W];
    logic [UPC_W-1:0]   upc_q;
    logic [UPC_W-1:0]   upc_inc;
    logic [UPC_W-1:0]   upc_nxt;
    logic [UPC_W-1:0]   stk_dout;
    logic [DEPTH_W-1:0] stk_depth;
    logic               stk_full;
    logic               stk_empty;
    logic               push;
    logic               pop;
    logic               flush;
    logic               set_ovf;
    logic               set_unf;
    logic               err_ovf_q;
    logic               err_unf_q;

    useq_stack #(
        .UPC_W       (UPC_W),
        .STACK_DEPTH (STACK_DEPTH),
        .DEPTH_W     (DEPTH_W)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (upc_inc),
        .dout  (stk_dout),
        .depth (stk_depth),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Writes land on the edge, so a same-cycle DISPATCH read still sees the old entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NUM_TBL; t++) begin
                for (int o = 0; o < 2**OPC_W; o++) begin
                    disp_ram[t][o] <= TRAP_UPC;
                end
            end
        end else if (bus.disp_we && (int'(bus.disp_tbl) < NUM_TBL)) begin
            disp_ram[bus.disp_tbl][bus.disp_opc] <= bus.disp_data;
        end
    end

    assign upc_inc = upc_q + UPC_W'(1);

    always_comb begin
        upc_nxt = upc_inc;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case (bus.next_sel)
            NEXT:     upc_nxt = upc_inc;
            JUMP:     upc_nxt = bus.target;
            BR_Z:     upc_nxt = bus.alu_zero ? bus.target : upc_inc;
            DISPATCH: upc_nxt = (int'(bus.tbl_sel) < NUM_TBL) ?
                                disp_ram[bus.tbl_sel][bus.opcode] : TRAP_UPC;
            WAIT:     upc_nxt = bus.mem_busy ? upc_q : upc_inc;
            CALL: begin
                if (stk_full) begin
                    upc_nxt = TRAP_UPC;
                    set_ovf = 1'b1;
                end else begin
                    upc_nxt = bus.target;
                    push    = 1'b1;
                end
            end
            RET: begin
                if (stk_empty) begin
                    upc_nxt = TRAP_UPC;
                    set_unf = 1'b1;
                end else begin
                    upc_nxt = stk_dout;
                    pop     = 1'b1;
                end
            end
            FETCH: begin
                upc_nxt = RESET_UPC;
                flush   = 1'b1;
            end
            default:  upc_nxt = upc_inc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upc_q     <= RESET_UPC;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            upc_q     <= upc_nxt;
            err_ovf_q <= err_ovf_q | set_ovf;
            err_unf_q <= err_unf_q | set_unf;
        end
    end

    assign bus.upc     = upc_q;
    assign bus.stall   = (bus.next_sel == WAIT) && bus.mem_busy;
    assign bus.depth   = stk_depth;
    assign bus.err_ovf = err_ovf_q;
    assign bus.err_unf = err_unf_q;

endmodule

// File: tb/tb_useq.sv
// Directed-vector bench for useq with hand-computed expected addresses and flags.
module tb_useq;
    import useq_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    useq_if #(.UPC_W(8), .OPC_W(7), .NUM_TBL(2), .STACK_DEPTH(4)) bus ();

    useq #(
        .UPC_W       (8),
        .OPC_W       (7),
        .NUM_TBL     (2),
        .STACK_DEPTH (4),
        .RESET_UPC   (8'h00),
        .TRAP_UPC    (8'hFF)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic uw(input next_e sel, input logic [7:0] tgt);
        bus.next_sel = sel;
        bus.target   = tgt;
    endtask

    task automatic chk_upc(input string name, input logic [7:0] exp);
        checks++;
        if (bus.upc !== exp) begin
            errors++;
            $display("FAIL %s upc=%h expected=%h", name, bus.upc, exp);
        end
    endtask

    task automatic chk_depth(input string name, input logic [2:0] exp);
        checks++;
        if (bus.depth !== exp) begin
            errors++;
            $display("FAIL %s depth=%0d expected=%0d", name, bus.depth, exp);
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.upc !== 8'h00) begin errors++; $display("FAIL rst_upc upc=%h expected=00", bus.upc); end
        checks++; if (bus.depth !== 3'd0) begin errors++; $display("FAIL rst_depth depth=%0d expected=0", bus.depth); end
        checks++; if ({bus.err_ovf, bus.err_unf} !== 2'b00) begin errors++; $display("FAIL rst_errs errs=%b expected=00", {bus.err_ovf, bus.err_unf}); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall stall=%b expected=0", bus.stall); end
        uw(NEXT, 8'h00);
        tick(); chk_upc("next1", 8'h01);
        tick(); chk_upc("next2", 8'h02);
        // Reset asserted mid-cycle together with a dispatch write that must be lost.
        reset = 1'b1;
        bus.disp_we = 1'b1; bus.disp_tbl = 1'b0; bus.disp_opc = 7'h05; bus.disp_data = 8'h12;
        #1;
        chk_upc("async_rst", 8'h00);
        tick();
        reset = 1'b0;
        bus.disp_we = 1'b0;
        tick(); chk_upc("after_rst", 8'h01);
        uw(DISPATCH, 8'h00); bus.tbl_sel = 1'b0; bus.opcode = 7'h05;
        tick(); chk_upc("rst_beats_we", 8'hFF);
    endtask

    task automatic test_dispatch();
        uw(NEXT, 8'h00);
        bus.disp_we = 1'b1; bus.disp_tbl = 1'b1; bus.disp_opc = 7'h33; bus.disp_data = 8'h40;
        tick();
        bus.disp_we = 1'b0;
        uw(DISPATCH, 8'h00); bus.tbl_sel = 1'b1; bus.opcode = 7'h33;
        tick(); chk_upc("disp_hit", 8'h40);
        bus.opcode = 7'h34;
        tick(); chk_upc("disp_unwritten", 8'hFF);
        bus.tbl_sel = 1'b0; bus.opcode = 7'h33;
        tick(); chk_upc("disp_other_tbl", 8'hFF);
        bus.disp_we = 1'b1; bus.disp_tbl = 1'b0; bus.disp_opc = 7'h10; bus.disp_data = 8'h77;
        bus.opcode = 7'h10;
        tick(); chk_upc("disp_same_cycle", 8'hFF);
        bus.disp_we = 1'b0;
        tick(); chk_upc("disp_next_cycle", 8'h77);
    endtask

    task automatic test_wait();
        uw(JUMP, 8'h10);
        tick(); chk_upc("jump10", 8'h10);
        uw(WAIT, 8'h00); bus.mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL wait_stall%0d stall=%b expected=1", i, bus.stall); end
            tick(); chk_upc("wait_hold", 8'h10);
        end
        bus.mem_busy = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL wait_release stall=%b expected=0", bus.stall); end
        tick(); chk_upc("wait_done", 8'h11);
    endtask

    task automatic test_call_ret();
        uw(JUMP, 8'h05); tick();
        uw(CALL, 8'h20); tick(); chk_upc("call1", 8'h20); chk_depth("call1", 3'd1);
        uw(JUMP, 8'h21); tick();
        uw(CALL, 8'h30); tick(); chk_upc("call2", 8'h30); chk_depth("call2", 3'd2);
        uw(RET, 8'h00);  tick(); chk_upc("ret1", 8'h22); chk_depth("ret1", 3'd1);
        tick(); chk_upc("ret2", 8'h06); chk_depth("ret2", 3'd0);
    endtask

    task automatic test_faults();
        for (int i = 0; i < 4; i++) begin
            uw(CALL, 8'h40 + 8'(i)); tick();
        end
        chk_depth("fill", 3'd4);
        checks++; if (bus.err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_pre err_ovf=%b expected=0", bus.err_ovf); end
        uw(CALL, 8'h50); tick(); chk_upc("ovf_trap", 8'hFF); chk_depth("ovf", 3'd4);
        checks++; if (bus.err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag err_ovf=%b expected=1", bus.err_ovf); end
        uw(FETCH, 8'h00); tick(); chk_upc("fetch", 8'h00); chk_depth("fetch", 3'd0);
        checks++; if (bus.err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky err_ovf=%b expected=1", bus.err_ovf); end
        uw(RET, 8'h00); tick(); chk_upc("unf_trap", 8'hFF); chk_depth("unf", 3'd0);
        checks++; if (bus.err_unf !== 1'b1) begin errors++; $display("FAIL unf_flag err_unf=%b expected=1", bus.err_unf); end
        uw(CALL, 8'h60); tick(); chk_upc("call_at_ff", 8'h60);
        uw(RET, 8'h00); tick(); chk_upc("ret_wrap", 8'h00);
    endtask

    task automatic test_branch();
        uw(JUMP, 8'h0A); tick();
        uw(BR_Z, 8'h50); bus.alu_zero = 1'b1; tick(); chk_upc("brz_taken", 8'h50);
        uw(JUMP, 8'h0A); tick();
        uw(BR_Z, 8'h50); bus.alu_zero = 1'b0; tick(); chk_upc("brz_not", 8'h0B);
        uw(JUMP, 8'hFF); tick();
        uw(NEXT, 8'h00); tick(); chk_upc("next_wrap", 8'h00);
        checks++; if (bus.err_unf !== 1'b1) begin errors++; $display("FAIL unf_sticky err_unf=%b expected=1", bus.err_unf); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.next_sel = NEXT; bus.target = 8'h00; bus.tbl_sel = 1'b0; bus.opcode = 7'h00;
        bus.alu_zero = 1'b0; bus.mem_busy = 1'b0; bus.disp_we = 1'b0;
        bus.disp_tbl = 1'b0; bus.disp_opc = 7'h00; bus.disp_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_dispatch();
        test_wait();
        test_call_ret();
        test_faults();
        test_branch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/useq.md
# useq

Parametrised microcode sequencer for the microcoded core, replacing the fixed next-uPC logic inside the control path. Each cycle it takes the sequencing fields of the current microword, plus the opcode, ALU-zero and memory-busy status, and registers the next microcode address (`upc`) that drives the microcode ROM. Beyond increment and jump, it adds:
- opcode dispatch through writable multi-table dispatch RAMs;
- a bounded micro-subroutine call/return stack;
- memory-wait stalling;
- trap redirection on stack faults.

## Interface
Parameters:
- UPC_W, 8, width of microcode address.
- OPC_W, 7, width of dispatch opcode (ir[6:0]).
- NUM_TBL, 2, number of dispatch tables (≥1).
- STACK_DEPTH, 4, return-stack entries (≥1).
- RESET_UPC, 0, upc value after reset and target of FETCH.
- TRAP_UPC, 8'hFF, upc taken on stack fault and reset value of every dispatch entry.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- next_sel  in  3  sequencing op from microword (`useq_pkg::next_e`).
- target  in  UPC_W  jump/branch/call target from microword.
- tbl_sel  in  $clog2(NUM_TBL) (min 1)  dispatch table index.
- opcode  in  OPC_W  dispatch key.
- alu_zero  in  1  ALU zero flag.
- mem_busy  in  1  memory busy.
- disp_we  in  1  dispatch RAM write strobe.
- disp_tbl  in  $clog2(NUM_TBL) (min 1)  table written.
- disp_opc  in  OPC_W  entry written.
- disp_data  in  UPC_W  value written.
- upc  out  UPC_W  current microcode address (registered).
- stall  out  1  combinational: next_sel==WAIT && mem_busy.
- depth  out  $clog2(STACK_DEPTH+1)  stack occupancy.
- err_ovf  out  1  sticky: CALL with full stack.
- err_unf  out  1  sticky: RET with empty stack.

## Operation
Next-address selection, by next_sel:
- NEXT: upc+1, wrapping modulo 2^UPC_W.
- JUMP: target.
- BR_Z: target if alu_zero, else upc+1.
- DISPATCH: dispatch[tbl_sel][opcode]. If tbl_sel ≥ NUM_TBL, go to TRAP_UPC.
- WAIT: hold upc while mem_busy; upc+1 on the first cycle mem_busy=0.
- CALL: push upc+1 (wrapped), go to target.
  - If depth==STACK_DEPTH: no push, set err_ovf, go to TRAP_UPC.
- RET: pop, go to popped value.
  - If depth==0: set err_unf, go to TRAP_UPC.
- FETCH: RESET_UPC; the stack is flushed (depth←0).

Dispatch RAM:
- NUM_TBL×2^OPC_W entries of UPC_W bits.
- Write when disp_we; an out-of-range disp_tbl is ignored.
- Read is combinational. A same-cycle write and DISPATCH read of the same entry returns the old value; the new value is visible next cycle.

Other rules:
- Error flags are cleared only by reset.
- Trap redirection does not alter stack contents.

## Timing
- Reset values (asynchronous):
  - upc=RESET_UPC, depth=0, err_ovf=0, err_unf=0.
  - All dispatch entries = TRAP_UPC.
  - stall=0 whenever next_sel≠WAIT.
- Latency: a decision made on the microword at upc in cycle N gives the new upc in cycle N+1. One microword per cycle, no bubbles.
- Reset mid-WAIT or mid-subroutine: the state is discarded; upc=RESET_UPC on the asserted reset.
- Reset dominates disp_we in the same cycle.
- Stack pointer update and upc update occur on the same edge.
- Boundary cases:
  - depth never exceeds STACK_DEPTH and never underflows.
  - For CALL at upc=2^UPC_W−1, the pushed value is 0.

## Structure
- `useq_pkg`:
  - next_e enum (NEXT=0, JUMP=1, BR_Z=2, DISPATCH=3, WAIT=4, CALL=5, RET=6, FETCH=7).
  - Helper function for clog2-with-min-1 widths.
- Sub-module `useq_stack`:
  - LIFO of STACK_DEPTH×UPC_W.
  - Ports: push, pop, flush, din, dout, depth, full, empty.
  - Same clk/reset.
- Dispatch RAM and next-address mux live in `useq`.

## Test plan
- Reset, then NEXT ×3 → upc 0,1,2,3. Assert reset in cycle 2 → upc=0 immediately (asynchronous). depth=0, errs 0.
- Write dispatch[1][7'h33]=8'h40. DISPATCH with tbl_sel=1, opcode=0x33 → upc=0x40 next cycle. Unwritten entry → 0xFF. Same-cycle write+read → old value.
- WAIT at upc=0x10 with mem_busy high 3 cycles → upc stays 0x10 and stall=1 for 3 cycles, then upc=0x11.
- CALL target 0x20 from 0x05, nested CALL 0x30 from 0x21, RET, RET → upc 0x20,0x30,0x22,0x06. depth 1,2,1,0.
- STACK_DEPTH=4: fifth CALL → upc=0xFF, err_ovf=1, depth=4. FETCH → upc=0, depth=0, err_ovf still 1. RET at depth 0 → upc=0xFF, err_unf=1.
- BR_Z target 0x50 at upc 0x0A: alu_zero=1 → 0x50; alu_zero=0 → 0x0B. NEXT at 0xFF → 0x00.
